// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory signals around the arbiter.
// The master modport is the arbiter's view; slave is the caches-plus-memory view.
interface cache_arbiter_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
);
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester physical-memory arbiter: I-cache fills vs D-cache fills/writebacks,
// round-robin on ties, one latched command in flight at a time.
module cache_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.master bus
);

  // state   | meaning
  // IDLE    | no command on memory; arbitrate pending requests
  // SERVE_I | I-cache fill in flight, wait for pmem_resp
  // SERVE_D | D-cache fill or writeback in flight, wait for pmem_resp
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant_d;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_busy;

  assign w_i_pend = bus.icache_pmem_read;
  assign w_d_pend = bus.dcache_pmem_read | bus.dcache_pmem_write;

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie D wins only if I was granted last.
        if (w_d_pend && (!w_i_pend || !r_last_grant_d)) begin
          w_grant_d = 1'b1;
          w_next    = SERVE_D;
        end else if (w_i_pend) begin
          w_grant_i = 1'b1;
          w_next    = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_write        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        r_last_grant_d <= 1'b1;
        r_addr         <= bus.dcache_pmem_address;
        r_wdata        <= bus.dcache_pmem_wdata;
        r_write        <= bus.dcache_pmem_write;
      end else if (w_grant_i) begin
        r_last_grant_d <= 1'b0;
        r_addr         <= bus.icache_pmem_address;
        r_wdata        <= '0;
        r_write        <= 1'b0;
      end
    end
  end

  // Commands come only from the latched copy, so requester changes cannot disturb them.
  assign w_busy             = (r_state != IDLE);
  assign bus.pmem_read      = w_busy & ~r_write;
  assign bus.pmem_write     = w_busy & r_write;
  assign bus.pmem_address   = r_addr;
  assign bus.pmem_wdata     = r_wdata;
  assign bus.icache_pmem_resp  = (r_state == SERVE_I) & bus.pmem_resp;
  assign bus.dcache_pmem_resp  = (r_state == SERVE_D) & bus.pmem_resp;
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;

endmodule
